rl_pair_gen_ctrl: RTL and testbench

- Parametrised, multi-channel successor to the single-stream home/neighbour pair address sequencer in the range-limited LJ top level.
- Generates home/neighbour position-RAM read addresses for NUM_CHANNEL independent filter channels. Home particles are interleaved across channels. Each channel stalls on its own back-pressure.
- Particle counts are runtime values. A same-cell (half-shell, j>i) mode is supported.
- Outputs RAM read enables, plus valid and particle IDs aligned to RAM read latency, feeding RL_LJ_Force_Evaluation_Unit filter inputs.

---
 rtl/rl_pair_gen_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_rl_pair_gen_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rl_pair_gen_ctrl.sv
// Multi-channel home/neighbour pair address sequencer for the range-limited LJ filters.
// Channel c walks homes c, c+NUM_CHANNEL, ... and every neighbour of each, stalling on its own back-pressure.
module rl_pair_gen_ctrl #(
  parameter int NUM_CHANNEL             = 4,
  parameter int REF_RAM_ADDR_WIDTH      = 7,
  parameter int NEIGHBOR_RAM_ADDR_WIDTH = 7,
  parameter int CELL_ID_WIDTH           = 12,
  parameter int PARTICLE_ID_WIDTH       = 20,
  parameter int RD_LATENCY              = 1,
  parameter int DRAIN_CYCLES            = 31
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [REF_RAM_ADDR_WIDTH:0]                  home_num,
  input  logic [NEIGHBOR_RAM_ADDR_WIDTH:0]             nb_num,
  input  logic                                         same_cell,
  input  logic [CELL_ID_WIDTH-1:0]                     home_cell_id,
  input  logic [CELL_ID_WIDTH-1:0]                     nb_cell_id,
  input  logic [NUM_CHANNEL-1:0]                       back_pressure,
  output logic [NUM_CHANNEL*REF_RAM_ADDR_WIDTH-1:0]      home_rdaddr,
  output logic [NUM_CHANNEL*NEIGHBOR_RAM_ADDR_WIDTH-1:0] nb_rdaddr,
  output logic [NUM_CHANNEL-1:0]                       rden,
  output logic [NUM_CHANNEL-1:0]                       input_valid,
  output logic [NUM_CHANNEL*PARTICLE_ID_WIDTH-1:0]     ref_particle_id,
  output logic [NUM_CHANNEL*PARTICLE_ID_WIDTH-1:0]     neighbor_particle_id,
  output logic                                         busy,
  output logic                                         done,
  output logic [31:0]                                  pair_count
);
  localparam int RW          = REF_RAM_ADDR_WIDTH;
  localparam int NW          = NEIGHBOR_RAM_ADDR_WIDTH;
  localparam int HCW         = RW + 1;
  localparam int NCW         = NW + 1;
  localparam int PW          = PARTICLE_ID_WIDTH;
  localparam int AW          = PARTICLE_ID_WIDTH - CELL_ID_WIDTH;
  localparam int DRAIN_TOTAL = RD_LATENCY + DRAIN_CYCLES;
  localparam int DCW         = $clog2(DRAIN_TOTAL + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                    r_state;
  logic [HCW-1:0]            r_home_num;
  logic [NCW-1:0]            r_nb_num;
  logic                      r_same_cell;
  logic [CELL_ID_WIDTH-1:0]  r_home_cell;
  logic [CELL_ID_WIDTH-1:0]  r_nb_cell;
  logic [HCW-1:0]            r_h [NUM_CHANNEL];
  logic [NCW-1:0]            r_n [NUM_CHANNEL];
  logic [NUM_CHANNEL*RW-1:0] r_home_addr;
  logic [NUM_CHANNEL*NW-1:0] r_nb_addr;
  logic [NUM_CHANNEL-1:0]    r_rden;
  logic [NUM_CHANNEL-1:0]    r_valid_pipe [RD_LATENCY];
  logic [NUM_CHANNEL*PW-1:0] r_ref_pipe   [RD_LATENCY];
  logic [NUM_CHANNEL*PW-1:0] r_nb_pipe    [RD_LATENCY];
  logic [DCW-1:0]            r_drain_cnt;
  logic                      r_busy;
  logic                      r_done;
  logic [31:0]               r_pair_count;

  logic [31:0]               w_h_eff [NUM_CHANNEL];
  logic [31:0]               w_n_eff [NUM_CHANNEL];
  logic [NUM_CHANNEL-1:0]    w_pend;
  logic [NUM_CHANNEL-1:0]    w_issue;
  logic [32:0]               w_sum;
  logic [NUM_CHANNEL*PW-1:0] w_ref_id;
  logic [NUM_CHANNEL*PW-1:0] w_nb_id;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    w_pend   = '0;
    w_issue  = '0;
    w_ref_id = '0;
    w_nb_id  = '0;
    w_sum    = {1'b0, r_pair_count};
    for (int c = 0; c < NUM_CHANNEL; c++) begin
      w_h_eff[c] = 32'(r_h[c]);
      w_n_eff[c] = 32'(r_n[c]);
      // One row skip suffices: if the next row is also empty, every later row is empty too.
      if (32'(r_n[c]) >= 32'(r_nb_num)) begin
        w_h_eff[c] = 32'(r_h[c]) + 32'(NUM_CHANNEL);
        w_n_eff[c] = r_same_cell ? 32'(r_h[c]) + 32'(NUM_CHANNEL) + 32'd1 : 32'd0;
      end
      w_pend[c]  = (w_h_eff[c] < 32'(r_home_num)) && (w_n_eff[c] < 32'(r_nb_num));
      w_issue[c] = (r_state == S_ISSUE) && w_pend[c] && !back_pressure[c];
      w_sum      = w_sum + 33'(r_rden[c]);
      // IDs carry the cell ID on top and the zero-extended address in the low field.
      if (r_rden[c]) begin
        w_ref_id[c*PW +: PW] = {r_home_cell, AW'(r_home_addr[c*RW +: RW])};
        w_nb_id[c*PW +: PW]  = {r_nb_cell, AW'(r_nb_addr[c*NW +: NW])};
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_home_num   <= '0;
      r_nb_num     <= '0;
      r_same_cell  <= 1'b0;
      r_home_cell  <= '0;
      r_nb_cell    <= '0;
      r_home_addr  <= '0;
      r_nb_addr    <= '0;
      r_rden       <= '0;
      r_drain_cnt  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pair_count <= '0;
      for (int c = 0; c < NUM_CHANNEL; c++) begin
        r_h[c] <= '0;
        r_n[c] <= '0;
      end
      // NOTE: the read-side pipelines are reset too, so a mid-run reset flushes stale valids and IDs.
      for (int s = 0; s < RD_LATENCY; s++) begin
        r_valid_pipe[s] <= '0;
        r_ref_pipe[s]   <= '0;
        r_nb_pipe[s]    <= '0;
      end
    end else begin
      r_done          <= 1'b0;
      r_rden          <= w_issue;
      r_pair_count    <= w_sum[32] ? '1 : w_sum[31:0];
      r_valid_pipe[0] <= r_rden;
      r_ref_pipe[0]   <= w_ref_id;
      r_nb_pipe[0]    <= w_nb_id;
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_valid_pipe[s] <= r_valid_pipe[s-1];
        r_ref_pipe[s]   <= r_ref_pipe[s-1];
        r_nb_pipe[s]    <= r_nb_pipe[s-1];
      end
      for (int c = 0; c < NUM_CHANNEL; c++) begin
        if (w_issue[c]) begin
          r_home_addr[c*RW +: RW] <= RW'(w_h_eff[c]);
          r_nb_addr[c*NW +: NW]   <= NW'(w_n_eff[c]);
          r_h[c]                  <= HCW'(w_h_eff[c]);
          r_n[c]                  <= NCW'(w_n_eff[c] + 32'd1);
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_home_num   <= home_num;
            r_nb_num     <= nb_num;
            r_same_cell  <= same_cell;
            r_home_cell  <= home_cell_id;
            r_nb_cell    <= nb_cell_id;
            r_pair_count <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_ISSUE;
            for (int c = 0; c < NUM_CHANNEL; c++) begin
              r_h[c] <= HCW'(c);
              r_n[c] <= same_cell ? NCW'(c + 1) : '0;
            end
          end
        end
        S_ISSUE: begin
          if (w_pend == '0) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DCW'(DRAIN_TOTAL - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign home_rdaddr          = r_home_addr;
  assign nb_rdaddr            = r_nb_addr;
  assign rden                 = r_rden;
  assign input_valid          = r_valid_pipe[RD_LATENCY-1];
  assign ref_particle_id      = r_ref_pipe[RD_LATENCY-1];
  assign neighbor_particle_id = r_nb_pipe[RD_LATENCY-1];
  assign busy                 = r_busy;
  assign done                 = r_done;
  assign pair_count           = r_pair_count;
endmodule

// File: tb/tb_rl_pair_gen_ctrl.sv
// Self-checking bench for rl_pair_gen_ctrl: a nested-loop model fills per-channel
// scoreboard queues, and a negedge monitor pops them as input_valid appears.
module tb_rl_pair_gen_ctrl;
  localparam int NC       = 2;
  localparam int RW       = 7;
  localparam int NW       = 7;
  localparam int CW       = 12;
  localparam int PW       = 20;
  localparam int AW       = PW - CW;
  localparam int RDL      = 1;
  localparam int DRN      = 31;
  localparam int DONE_LAT = 1 + RDL + DRN;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [RW:0]       home_num = '0;
  logic [NW:0]       nb_num = '0;
  logic              same_cell = 1'b0;
  logic [CW-1:0]     home_cell_id = '0;
  logic [CW-1:0]     nb_cell_id = '0;
  logic [NC-1:0]     back_pressure = '0;
  logic [NC*RW-1:0]  home_rdaddr;
  logic [NC*NW-1:0]  nb_rdaddr;
  logic [NC-1:0]     rden;
  logic [NC-1:0]     input_valid;
  logic [NC*PW-1:0]  ref_particle_id;
  logic [NC*PW-1:0]  neighbor_particle_id;
  logic              busy;
  logic              done;
  logic [31:0]       pair_count;

  always #5 clk = ~clk;

  rl_pair_gen_ctrl #(
    .NUM_CHANNEL(NC), .REF_RAM_ADDR_WIDTH(RW), .NEIGHBOR_RAM_ADDR_WIDTH(NW),
    .CELL_ID_WIDTH(CW), .PARTICLE_ID_WIDTH(PW), .RD_LATENCY(RDL), .DRAIN_CYCLES(DRN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .home_num(home_num), .nb_num(nb_num),
    .same_cell(same_cell), .home_cell_id(home_cell_id), .nb_cell_id(nb_cell_id),
    .back_pressure(back_pressure), .home_rdaddr(home_rdaddr), .nb_rdaddr(nb_rdaddr),
    .rden(rden), .input_valid(input_valid), .ref_particle_id(ref_particle_id),
    .neighbor_particle_id(neighbor_particle_id), .busy(busy), .done(done),
    .pair_count(pair_count)
  );

  typedef struct packed {
    logic [PW-1:0] ref_id;
    logic [PW-1:0] nb_id;
  } pair_t;

  pair_t         exp_q [NC][$];
  int            exp_cnt [NC];
  int            exp_total;
  logic [PW-1:0] last_ref [NC];
  logic [PW-1:0] last_nb  [NC];
  logic [NC-1:0] prev_rden = '0;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference order: channel h%NC owns home h; neighbours ascend from 0 (or h+1 in same-cell mode).
  task automatic load_expected(input int hn, input int nn, input bit sc,
                               input logic [CW-1:0] hc, input logic [CW-1:0] nbc);
    pair_t p;
    exp_total = 0;
    for (int c = 0; c < NC; c++) begin
      exp_q[c].delete();
      exp_cnt[c] = 0;
    end
    for (int h = 0; h < hn; h++) begin
      for (int n = (sc ? h + 1 : 0); n < nn; n++) begin
        p.ref_id = {hc, AW'(h)};
        p.nb_id  = {nbc, AW'(n)};
        exp_q[h % NC].push_back(p);
        exp_cnt[h % NC]++;
        exp_total++;
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    pair_t p;
    if (!rst) begin
      prev_rden = '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        check($sformatf("iv_align_ch%0d", c), 64'(input_valid[c]), 64'(prev_rden[c]));
        if (input_valid[c]) begin
          check($sformatf("sb_entry_ch%0d", c), 64'(exp_q[c].size() > 0), 64'd1);
          if (exp_q[c].size() > 0) begin
            p = exp_q[c].pop_front();
            check($sformatf("ref_id_ch%0d", c), 64'(ref_particle_id[c*PW +: PW]), 64'(p.ref_id));
            check($sformatf("nb_id_ch%0d", c), 64'(neighbor_particle_id[c*PW +: PW]), 64'(p.nb_id));
            last_ref[c] = ref_particle_id[c*PW +: PW];
            last_nb[c]  = neighbor_particle_id[c*PW +: PW];
          end
        end else begin
          check($sformatf("ref_id_zero_ch%0d", c), 64'(ref_particle_id[c*PW +: PW]), 64'd0);
          check($sformatf("nb_id_zero_ch%0d", c), 64'(neighbor_particle_id[c*PW +: PW]), 64'd0);
        end
      end
      prev_rden = rden;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rden"}, 64'(rden), 64'd0);
    check({tag, "_input_valid"}, 64'(input_valid), 64'd0);
    check({tag, "_home_rdaddr"}, 64'(home_rdaddr), 64'd0);
    check({tag, "_nb_rdaddr"}, 64'(nb_rdaddr), 64'd0);
    check({tag, "_ref_id"}, 64'(ref_particle_id), 64'd0);
    check({tag, "_nb_id"}, 64'(neighbor_particle_id), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pair_count"}, 64'(pair_count), 64'd0);
  endtask

  task automatic run_case(input string name, input int hn, input int nn, input bit sc,
                          input logic [CW-1:0] hc, input logic [CW-1:0] nbc, input bit stall);
    int            n;
    int            last_rd;
    bit            got_done;
    logic [NC-1:0] first_mask;
    logic [RW-1:0] held_h;
    logic [NW-1:0] held_n;
    load_expected(hn, nn, sc, hc, nbc);
    for (int c = 0; c < NC; c++) first_mask[c] = (exp_cnt[c] > 0);
    home_num = (RW+1)'(hn);
    nb_num = (NW+1)'(nn);
    same_cell = sc;
    home_cell_id = hc;
    nb_cell_id = nbc;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_busy_after_start"}, 64'(busy), 64'd1);
    check({name, "_count_cleared"}, 64'(pair_count), 64'd0);
    // Inputs change after acceptance; the latched run must not notice.
    home_num = '1;
    nb_num = '1;
    same_cell = ~sc;
    home_cell_id = ~hc;
    nb_cell_id = ~nbc;
    held_h = '0;
    held_n = '0;
    n = 0;
    last_rd = 0;
    got_done = 1'b0;
    while (!got_done && n < 3000) begin
      start = (n == 1);
      if (stall && n == 2) begin
        back_pressure[1] = 1'b1;
        held_h = home_rdaddr[RW +: RW];
        held_n = nb_rdaddr[NW +: NW];
      end
      if (stall && n == 7) back_pressure[1] = 1'b0;
      tick();
      n++;
      if (n == 1) check({name, "_first_issue"}, 64'(rden), 64'(first_mask));
      if (stall && n >= 3 && n <= 7) begin
        check({name, "_stall_rden1"}, 64'(rden[1]), 64'd0);
        check({name, "_stall_home_hold"}, 64'(home_rdaddr[RW +: RW]), 64'(held_h));
        check({name, "_stall_nb_hold"}, 64'(nb_rdaddr[NW +: NW]), 64'(held_n));
        check({name, "_stall_rden0"}, 64'(rden[0]), 64'd1);
      end
      if (|rden) last_rd = n;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check({name, "_done_seen"}, 64'(got_done), 64'd1);
    if (got_done) begin
      check({name, "_done_latency"}, 64'(n - last_rd), 64'(DONE_LAT));
      check({name, "_pair_count"}, 64'(pair_count), 64'(exp_total));
      for (int c = 0; c < NC; c++)
        check($sformatf("%s_sb_drained_ch%0d", name, c), 64'(exp_q[c].size()), 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({name, "_done_one_cycle"}, 64'(done), 64'd0);
      check({name, "_start_in_done_ignored"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int dn;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    run_case("basic", 3, 2, 1'b0, 12'h005, 12'h00A, 1'b0);
    run_case("same_cell", 4, 4, 1'b1, 12'h011, 12'h011, 1'b0);
    run_case("id_fmt", 4, 8, 1'b0, 12'h005, 12'h00A, 1'b0);
    check("id_fmt_ref_h3", 64'(last_ref[1]), 64'h00503);
    check("id_fmt_nb_n7", 64'(last_nb[1]), 64'h00A07);
    run_case("stall", 4, 4, 1'b0, 12'h123, 12'h456, 1'b1);
    run_case("home_zero", 0, 5, 1'b0, 12'h001, 12'h002, 1'b0);
    run_case("nb_zero", 3, 0, 1'b0, 12'h001, 12'h002, 1'b0);
    run_case("same_single", 1, 1, 1'b1, 12'h003, 12'h003, 1'b0);
    run_case("full_ram", 128, 1, 1'b0, 12'hFFF, 12'h800, 1'b0);

    // Abort a run with reset, then confirm a clean restart.
    load_expected(8, 8, 1'b0, 12'h0AA, 12'h0BB);
    home_num = 8'd8;
    nb_num = 8'd8;
    same_cell = 1'b0;
    home_cell_id = 12'h0AA;
    nb_cell_id = 12'h0BB;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    check_all_zero("abort");
    for (int c = 0; c < NC; c++) exp_q[c].delete();
    rst = 1'b1;
    dn = 0;
    repeat (45) begin
      tick();
      if (done) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);
    run_case("post_reset", 5, 6, 1'b1, 12'h00C, 12'h00C, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
